// File: rtl/bias_seq_ctrl_if.sv
// ---- bias_seq_ctrl_if : accumulator-in / result-out stream bundle (rev 1.0) ----
`timescale 1ns/1ps
`default_nettype none

interface bias_seq_ctrl_if #(
  parameter int N_adder_tree = 16
) ();
  logic                        acc_valid;
  logic [N_adder_tree*18-1:0]  acc_data;
  logic                        acc_ready;
  logic                        out_valid;
  logic [N_adder_tree*18-1:0]  out_data;
  logic                        out_ready;

  modport master (
    output acc_valid, acc_data, out_ready,
    input  acc_ready, out_valid, out_data
  );

  modport slave (
    input  acc_valid, acc_data, out_ready,
    output acc_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/bias_seq_ctrl.sv
// ---- bias_seq_ctrl : per-group bias add, saturate and optional ReLU sequencer (rev 1.0) ----
`timescale 1ns/1ps
`default_nettype none

module bias_seq_ctrl #(
  parameter int N_adder_tree = 16,
  parameter int N_GROUPS     = 4,
  parameter int PIXELS       = 49,
  parameter int RELU         = 1,
  localparam int GW = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  wire logic                                clk,
  input  wire logic                                rst,
  input  wire logic                                start,
  bias_seq_ctrl_if.slave                           bus,
  input  wire logic [N_GROUPS*N_adder_tree*18-1:0] bias_bank,
  output logic [GW-1:0]                            group_idx,
  output logic [PW-1:0]                            pixel_cnt,
  output logic                                     busy,
  output logic                                     done
);

  localparam int             LANE_BITS = N_adder_tree * 18;
  localparam logic [GW-1:0]  GRP_LAST  = GW'(N_GROUPS - 1);
  localparam logic [PW-1:0]  PIX_LAST  = PW'(PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   accept;
  logic                   pix_wrap;
  logic                   last_beat;
  logic [LANE_BITS-1:0]   bias_vec;
  logic [LANE_BITS-1:0]   result;

  assign bus.acc_ready = (state == RUN) && (!bus.out_valid || bus.out_ready);
  assign accept        = bus.acc_valid && bus.acc_ready;
  assign pix_wrap      = (pixel_cnt == PIX_LAST);
  assign last_beat     = pix_wrap && (group_idx == GRP_LAST);
  assign busy          = (state == RUN) || (state == DRAIN);
  assign done          = (state == DONE);

  // Bias is taken from the group in force before this beat's counter update.
  assign bias_vec = bias_bank[int'(group_idx) * LANE_BITS +: LANE_BITS];

  for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
    logic [17:0] a;
    logic [17:0] b;
    logic [18:0] sum;
    logic [17:0] sat;

    assign a   = bus.acc_data[18*k +: 18];
    assign b   = bias_vec[18*k +: 18];
    assign sum = {a[17], a} + {b[17], b};

    always_comb begin
      sat = sum[17:0];
      if (sum[18] != sum[17]) begin
        sat = sum[18] ? 18'h20000 : 18'h1FFFF;
      end
      if ((RELU != 0) && sat[17]) begin
        sat = '0;
      end
    end

    assign result[18*k +: 18] = sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_beat) state_nxt = DRAIN;
      DRAIN:   if (!bus.out_valid || bus.out_ready) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      group_idx <= '0;
      pixel_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      group_idx <= '0;
      pixel_cnt <= '0;
    end else if (accept) begin
      if (pix_wrap) begin
        pixel_cnt <= '0;
        group_idx <= (group_idx == GRP_LAST) ? '0 : group_idx + 1'b1;
      end else begin
        pixel_cnt <= pixel_cnt + 1'b1;
      end
    end
  end

  // A new beat may replace a result in the same cycle it is handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= result;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bias_seq_ctrl.sv
// ---- tb_bias_seq_ctrl : directed bench with a beat-count reference model (rev 1.0) ----
`timescale 1ns/1ps
`default_nettype none

module tb_bias_seq_ctrl;

  localparam int NL = 4;
  localparam int NG = 4;
  localparam int P  = 2;
  localparam int LW = NL * 18;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               acc_valid;
  logic [LW-1:0]      acc_data;
  logic               out_ready;
  logic [NG*LW-1:0]   bias_bank;

  logic [1:0] grp0, grp1;
  logic [0:0] pix0, pix1;
  logic       busy0, busy1, done0, done1;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  always #5 clk = ~clk;

  bias_seq_ctrl_if #(.N_adder_tree(NL)) if0 ();
  bias_seq_ctrl_if #(.N_adder_tree(NL)) if1 ();

  assign if0.acc_valid = acc_valid;
  assign if0.acc_data  = acc_data;
  assign if0.out_ready = out_ready;
  assign if1.acc_valid = acc_valid;
  assign if1.acc_data  = acc_data;
  assign if1.out_ready = out_ready;

  bias_seq_ctrl #(.N_adder_tree(NL), .N_GROUPS(NG), .PIXELS(P), .RELU(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(if0.slave), .bias_bank(bias_bank),
    .group_idx(grp0), .pixel_cnt(pix0), .busy(busy0), .done(done0)
  );

  bias_seq_ctrl #(.N_adder_tree(NL), .N_GROUPS(NG), .PIXELS(P), .RELU(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(if1.slave), .bias_bank(bias_bank),
    .group_idx(grp1), .pixel_cnt(pix1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected completion at %0t", name, $time);
  endtask

  function automatic int lane_of(input logic [LW-1:0] v, input int k);
    logic signed [17:0] x;
    x = v[18*k +: 18];
    return int'(x);
  endfunction

  function automatic int lane_res(input int a, input int b, input bit relu);
    int s;
    s = a + b;
    if (s > 131071)  s = 131071;
    if (s < -131072) s = -131072;
    if (relu && s < 0) s = 0;
    return s;
  endfunction

  function automatic int bias_of(input int g, input int k);
    logic signed [17:0] x;
    x = bias_bank[18*(g*NL + k) +: 18];
    return int'(x);
  endfunction

  // Reference: position derives from the number of beats accepted this pass.
  int            m_state = 0;   // 0 idle, 1 run, 2 drain, 3 done
  int            m_beats = 0;
  bit            m_ov    = 1'b0;
  bit            m_init  = 1'b0;
  logic [LW-1:0] m_od0   = '0;
  logic [LW-1:0] m_od1   = '0;

  always @(posedge clk) begin
    int  g;
    bit  rdy, acpt, hs;
    if (rst) begin
      m_state = 0; m_beats = 0; m_ov = 1'b0; m_od0 = '0; m_od1 = '0; m_init = 1'b1;
    end else begin
      g    = (m_beats / P) % NG;
      rdy  = (m_state == 1) && (!m_ov || out_ready);
      acpt = rdy && acc_valid;
      hs   = m_ov && out_ready;
      case (m_state)
        0: if (start) begin m_state = 1; m_beats = 0; end
        1: if (acpt && m_beats == NG*P - 1) m_state = 2;
        2: if (!m_ov || out_ready) m_state = 3;
        default: m_state = 0;
      endcase
      if (acpt) begin
        for (int k = 0; k < NL; k++) begin
          m_od0[18*k +: 18] = 18'(lane_res(lane_of(acc_data, k), bias_of(g, k), 1'b0));
          m_od1[18*k +: 18] = 18'(lane_res(lane_of(acc_data, k), bias_of(g, k), 1'b1));
        end
        m_ov = 1'b1;
        m_beats++;
      end else if (hs) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit exp_rdy;
    if (m_init) begin
      exp_rdy = (m_state == 1) && (!m_ov || out_ready);
      chk("acc_ready",      if0.acc_ready, exp_rdy);
      chk("acc_ready_relu", if1.acc_ready, exp_rdy);
      chk("out_valid",      if0.out_valid, m_ov);
      chk("out_valid_relu", if1.out_valid, m_ov);
      chk("out_data",       if0.out_data,  m_od0);
      chk("out_data_relu",  if1.out_data,  m_od1);
      chk("busy",           busy0, (m_state == 1) || (m_state == 2));
      chk("busy_relu",      busy1, (m_state == 1) || (m_state == 2));
      chk("done",           done0, m_state == 3);
      chk("done_relu",      done1, m_state == 3);
      chk("group_idx",      grp0, 128'((m_beats / P) % NG));
      chk("pixel_cnt",      pix0, 128'(m_beats % P));
      chk("group_idx_relu", grp1, 128'((m_beats / P) % NG));
      chk("pixel_cnt_relu", pix1, 128'(m_beats % P));
      if (done0) done_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [LW-1:0] d);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    acc_valid = 1'b1;
    acc_data  = d;
    while (!got && n < 50) begin
      @(negedge clk);
      if (if0.acc_ready) got = 1'b1;
      else n++;
      tick();
    end
    acc_valid = 1'b0;
    if (!got) fail_now("beat_accept");
  endtask

  function automatic logic [LW-1:0] rand_vec();
    logic [LW-1:0] v;
    for (int k = 0; k < NL; k++) v[18*k +: 18] = 18'($urandom);
    return v;
  endfunction

  function automatic logic [LW-1:0] fill(input int l0, input int rest);
    logic [LW-1:0] v;
    for (int k = 0; k < NL; k++) v[18*k +: 18] = 18'((k == 0) ? l0 : rest);
    return v;
  endfunction

  task automatic run_beats(input int n);
    for (int i = 0; i < n; i++) send_beat(rand_vec());
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_seen;
    repeat (10) @(negedge clk);
    chk("done_pulses", 128'(done_seen - d0), 128'(1));
    chk("final_group", grp0, 128'(0));
    tick();
  endtask

  initial begin
    logic [LW-1:0] v;
    rst = 1'b1; start = 1'b0; acc_valid = 1'b0; acc_data = '0; out_ready = 1'b1;
    for (int g = 0; g < NG; g++)
      for (int k = 0; k < NL; k++)
        bias_bank[18*(g*NL + k) +: 18] = 18'((k == 3) ? -(g + 1) * 50 : (g + 1) * 100 + k * 10);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", if0.out_valid, 1'b0);
    chk("reset_busy",      busy0, 1'b0);
    chk("reset_out_data",  if0.out_data, '0);

    // Basic add followed by a full pass walking through every group.
    do_start();
    send_beat(fill(1000, 5));
    chk("basic_lane0", 128'(lane_of(if0.out_data, 0)), 128'(1100));
    chk("basic_pixel", pix0, 128'(1));
    for (int i = 1; i < NG*P; i++) begin
      send_beat(fill(0, 1));
      chk("wrap_bias_lane0", 128'(lane_of(if0.out_data, 0)), 128'((i / 2 + 1) * 100));
    end
    wait_done();

    // Saturation in both directions, with and without ReLU.
    bias_bank[0 +: 18]  = 18'(1000);
    bias_bank[18 +: 18] = 18'(-1000);
    do_start();
    v = '0;
    v[0 +: 18]  = 18'(131000);
    v[18 +: 18] = 18'(-131000);
    send_beat(v);
    chk("sat_pos",      128'(lane_of(if0.out_data, 0)), 128'(131071));
    chk("sat_neg",      128'(lane_of(if0.out_data, 1)), 128'(-131072));
    chk("sat_pos_relu", 128'(lane_of(if1.out_data, 0)), 128'(131071));
    chk("sat_neg_relu", 128'(lane_of(if1.out_data, 1)), 128'(0));
    run_beats(NG*P - 1);
    wait_done();
    bias_bank[0 +: 18]  = 18'(100);
    bias_bank[18 +: 18] = 18'(110);

    // Backpressure mid-pass and while draining the final result.
    do_start();
    send_beat(fill(10, 10));
    out_ready = 1'b0;
    acc_valid = 1'b1;
    acc_data  = fill(20, 20);
    repeat (5) begin
      @(negedge clk);
      chk("stall_acc_ready", if0.acc_ready, 1'b0);
      chk("stall_hold_lane0", 128'(lane_of(if0.out_data, 0)), 128'(110));
    end
    tick();
    out_ready = 1'b1;
    send_beat(fill(20, 20));
    chk("release_lane0", 128'(lane_of(if0.out_data, 0)), 128'(120));
    run_beats(NG*P - 3);
    send_beat(rand_vec());
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("drain_busy", busy0, 1'b1);
    end
    tick();
    out_ready = 1'b1;
    wait_done();

    // Reset in the middle of a pass, then a clean restart.
    do_start();
    run_beats(5);
    chk("pre_reset_group", grp0, 128'(2));
    chk("pre_reset_pixel", pix0, 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_out_valid", if0.out_valid, 1'b0);
    chk("rst_out_data",  if0.out_data, '0);
    chk("rst_acc_ready", if0.acc_ready, 1'b0);
    chk("rst_busy",      busy0, 1'b0);
    chk("rst_done",      done0, 1'b0);
    chk("rst_group",     grp0, 128'(0));
    chk("rst_pixel",     pix0, 128'(0));
    do_start();
    send_beat(rand_vec());
    chk("restart_group", grp0, 128'(0));
    chk("restart_pixel", pix0, 128'(1));
    run_beats(NG*P - 1);
    wait_done();

    // A start pulse while running must not disturb the pass.
    do_start();
    run_beats(3);
    do_start();
    chk("start_in_run_group", grp0, 128'(1));
    chk("start_in_run_pixel", pix0, 128'(1));
    run_beats(NG*P - 3);
    wait_done();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/bias_seq_ctrl.md
BIAS_SEQ_CTRL -- requirements
Module: bias_seq_ctrl

Interface
REQ-001 SHALL have parameter N_adder_tree, default 16, giving the number of 18-bit lanes per beat.
REQ-002 SHALL have parameter N_GROUPS, default 4, giving the number of filter groups, each with its own bias vector.
REQ-003 SHALL have parameter PIXELS, default 49, giving the number of accumulator beats per group.
REQ-004 SHALL have parameter RELU, default 1; 1 enables ReLU after bias add.
REQ-005 SHALL have ports clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have ports rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have ports start, input, 1 bit: one-cycle pulse that begins a layer pass.
REQ-008 SHALL have ports acc_valid, input, 1 bit: accumulator beat valid.
REQ-009 SHALL have ports acc_data, input, N_adder_tree*18 bits: signed lane sums, lane k at [18k+17:18k].
REQ-010 SHALL have ports acc_ready, output, 1 bit: beat accepted when acc_valid and acc_ready are both high.
REQ-011 SHALL have ports bias_bank, input, N_GROUPS*N_adder_tree*18 bits: group g, lane k at offset 18*(g*N_adder_tree+k).
REQ-012 SHALL have ports out_valid, output, 1 bit, and out_data, output, N_adder_tree*18 bits: biased result.
REQ-013 SHALL have ports out_ready, input, 1 bit: downstream accept.
REQ-014 SHALL have ports group_idx, output, clog2(N_GROUPS) bits, and pixel_cnt, output, clog2(PIXELS) bits: current position.
REQ-015 SHALL have ports busy, output, 1 bit, and done, output, 1 bit: done is a one-cycle pulse at pass end.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
REQ-017 SHALL move IDLE->RUN on start.
REQ-018 SHALL move RUN->DRAIN when the last beat of the last group (group_idx=N_GROUPS-1, pixel_cnt=PIXELS-1) is accepted.
REQ-019 SHALL move DRAIN->DONE when out_valid is low or out_valid and out_ready are both high.
REQ-020 SHALL move DONE->IDLE unconditionally after one cycle.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL assert busy in RUN and DRAIN, and done only in DONE.
REQ-023 SHALL drive acc_ready = (state==RUN) AND (NOT out_valid OR out_ready); beats are never accepted in IDLE, DRAIN or DONE.
REQ-024 SHALL, per accepted beat, compute each lane as the 19-bit signed sum of acc lane k and the bias_bank lane selected by the current group_idx.
REQ-025 SHALL saturate each 19-bit sum to the range [-131072, +131071].
REQ-026 SHALL, if RELU=1, replace negative saturated results with 0.
REQ-027 SHALL register each result into out_data with out_valid high on the next cycle, giving latency 1.
REQ-028 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-029 SHALL clear out_valid on handshake unless a new beat is accepted in the same cycle.
REQ-030 SHALL increment pixel_cnt on each accepted beat; at PIXELS-1 it wraps to 0 and group_idx increments.
REQ-031 SHALL return group_idx to 0 after N_GROUPS-1 wraps.
REQ-032 SHALL use the pre-increment group_idx for the bias of the beat being accepted.
REQ-033 SHALL clear pixel_cnt and group_idx to 0 on the IDLE->RUN transition.
REQ-034 SHALL not stall or change counters when acc_valid is low in RUN.

Reset
REQ-035 SHALL, on rst high at any clock edge including mid-pass, set state=IDLE, out_valid=0, out_data=0, acc_ready=0, busy=0, done=0, group_idx=0, pixel_cnt=0.
REQ-036 SHALL discard any pending output on reset.
REQ-037 SHALL give rst priority over start and all handshakes.

Verification
REQ-038 SHALL verify basic add: N_GROUPS=4, PIXELS=2, RELU=0, lane0 acc 1000, group0 bias 100, out_ready=1 -> out lane0 1100 one cycle after accept; pixel_cnt 1.
REQ-039 SHALL verify saturation: acc +131000, bias +1000 -> 131071; acc -131000, bias -1000 -> -131072 with RELU=0, 0 with RELU=1.
REQ-040 SHALL verify group wrap: 8 beats accepted back-to-back -> biases of groups 0,0,1,1,2,2,3,3 applied; DRAIN then done pulse exactly once; final group_idx 0.
REQ-041 SHALL verify backpressure: out_ready=0 for 5 cycles with acc_valid=1 -> acc_ready=0 after the first beat, out_data unchanged; release -> no beat lost or duplicated.
REQ-042 SHALL verify reset mid-pass: rst at group 2, pixel 1 -> next cycle all outputs zero, state IDLE; start -> counts restart from 0,0.
REQ-043 SHALL verify start in RUN: start pulse during RUN -> no counter reset, pass completes normally.
